// File: rtl/ldl_sfifo_ctl.sv
// Show-ahead valid/ready FIFO controller around an external pseudo-dual-port RAM
// with a registered read port; a 2-entry output stage hides the read latency.
module ldl_sfifo_ctl #(
  parameter int DWIDTH = 8,
  parameter int DEEPTH = 10,
  parameter int AWIDTH = $clog2(DEEPTH),
  parameter int CWIDTH = $clog2(DEEPTH + 3)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic [CWIDTH-1:0] level,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_wa,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_ra,
  input  logic [DWIDTH-1:0] ram_dout
);

  logic [AWIDTH-1:0] wptr, rptr;
  logic [CWIDTH-1:0] ram_cnt, ram_cnt_nxt, level_nxt;
  logic              rd_pend;
  logic              head_v, skid_v, head_v_nxt, skid_v_nxt;
  logic [DWIDTH-1:0] head_q, skid_q;
  logic              head_ld_ram, head_ld_skid, skid_ld;
  logic              push, pop;
  logic [1:0]        ostage_cnt;
  logic [2:0]        occ_after;

  function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
    return (p == AWIDTH'(DEEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request side: RAM write and read issue
  assign wr_ready   = (ram_cnt != CWIDTH'(DEEPTH));
  assign push       = wr_valid & wr_ready;
  assign pop        = head_v & rd_ready;
  assign ostage_cnt = {1'b0, head_v} + {1'b0, skid_v};
  // Occupancy of the output stage once this cycle's pop leaves; pop implies head_v, so no underflow.
  assign occ_after  = {1'b0, ostage_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign ram_re     = (ram_cnt != '0) && (occ_after < 3'd2);

  assign ram_we  = push;
  assign ram_wa  = wptr;
  assign ram_din = wr_data;
  assign ram_ra  = rptr;

  assign rd_valid = head_v;
  assign rd_data  = head_q;

  always_comb begin
    ram_cnt_nxt  = ram_cnt + CWIDTH'(push) - CWIDTH'(ram_re);
    head_v_nxt   = head_v;
    skid_v_nxt   = skid_v;
    head_ld_ram  = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (pop) begin
      if (skid_v) begin
        head_ld_skid = 1'b1;
        if (rd_pend) skid_ld = 1'b1;
        else         skid_v_nxt = 1'b0;
      end else if (rd_pend) begin
        head_ld_ram = 1'b1;
      end else begin
        head_v_nxt = 1'b0;
      end
    end else if (rd_pend) begin
      if (!head_v) begin
        head_ld_ram = 1'b1;
        head_v_nxt  = 1'b1;
      end else begin
        skid_ld    = 1'b1;
        skid_v_nxt = 1'b1;
      end
    end
    level_nxt = ram_cnt_nxt + CWIDTH'(ram_re) + CWIDTH'(head_v_nxt) + CWIDTH'(skid_v_nxt);
  end

  // Stage p1: pointers, counters, in-flight read flag, output stage occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      head_v  <= 1'b0;
      skid_v  <= 1'b0;
      level   <= '0;
      head_q  <= '0;
    end else begin
      if (push)   wptr <= ptr_inc(wptr);
      if (ram_re) rptr <= ptr_inc(rptr);
      ram_cnt <= ram_cnt_nxt;
      rd_pend <= ram_re;
      head_v  <= head_v_nxt;
      skid_v  <= skid_v_nxt;
      level   <= level_nxt;
      if (head_ld_ram)       head_q <= ram_dout;
      else if (head_ld_skid) head_q <= skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_ld) skid_q <= ram_dout;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) ram_we |-> wr_ready);
  a_no_re_empty:  assert property (@(posedge clk) disable iff (!rst_n) ram_re |-> (ram_cnt != '0));
  a_ostage_max:   assert property (@(posedge clk) disable iff (!rst_n) ostage_cnt <= 2'd2);
  a_skid_free:    assert property (@(posedge clk) disable iff (!rst_n) !(rd_pend && skid_v && !pop));

endmodule

// File: tb/tb_ldl_sfifo_ctl.sv
// Directed bench for ldl_sfifo_ctl with a RAM model and a push/pop scoreboard.
module tb_ldl_sfifo_ctl;
  localparam int DW = 8;
  localparam int DP = 10;
  localparam int AW = $clog2(DP);
  localparam int CW = $clog2(DP + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, ram_we, ram_re;
  logic [DW-1:0] rd_data, ram_din, ram_dout;
  logic [CW-1:0] level;
  logic [AW-1:0] ram_wa, ram_ra;

  logic [DW-1:0] mem [DP];

  int checks = 0, failures = 0;
  logic [DW-1:0] sb[$];
  int exp_wa = 0, exp_ra = 0, n_push = 0, n_pop = 0;
  logic hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  ldl_sfifo_ctl #(.DWIDTH(DW), .DEEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .level(level),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_din(ram_din), .ram_re(ram_re), .ram_ra(ram_ra),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Per-cycle observation at the falling edge: RAM port model, scoreboard, hold rule.
  task automatic sample();
    logic [DW-1:0] e;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_valid", rd_valid, 1);
      chk("hold_data", rd_data, hold_data);
    end
    if (wr_valid && wr_ready) begin
      chk("ram_we", ram_we, 1);
      chk("ram_wa", ram_wa, exp_wa);
      chk("ram_din", ram_din, wr_data);
      sb.push_back(wr_data);
      exp_wa = (exp_wa == DP - 1) ? 0 : exp_wa + 1;
      n_push++;
    end else begin
      chk("ram_we_idle", ram_we, 0);
    end
    if (ram_re) begin
      chk("ram_ra", ram_ra, exp_ra);
      exp_ra = (exp_ra == DP - 1) ? 0 : exp_ra + 1;
    end
    if (rd_valid && rd_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL pop_underflow observed=%0h expected=no_pop", rd_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e);
      end
      n_pop++;
    end
    checks++;
    assert (level <= CW'(DP + 2)) else begin
      failures++;
      $error("FAIL level_max observed=%0d expected=<=%0d", level, DP + 2);
    end
    hold_prev = rd_valid && !rd_ready;
    hold_data = rd_data;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    int base, acc, c;
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_wr_ready", wr_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single word latency
    wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b1;
    sample();
    chk("t1_we", ram_we, 1);
    chk("t1_wa", ram_wa, 0);
    adv();
    wr_valid = 1'b0;
    sample();
    chk("t1_re", ram_re, 1);
    chk("t1_ra", ram_ra, 0);
    chk("t1_v1", rd_valid, 0);
    adv();
    sample();
    chk("t1_v2", rd_valid, 0);
    chk("t1_lvl2", level, 1);
    adv();
    sample();
    chk("t1_v3", rd_valid, 1);
    chk("t1_d3", rd_data, 8'h5A);
    adv();
    sample();
    chk("t1_lvl_end", level, 0);
    chk("t1_v_end", rd_valid, 0);
    adv();

    // 2: fill to capacity with the consumer stalled
    rd_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      sample();
      chk("t2_wr_ready", wr_ready, 1);
      adv();
    end
    wr_valid = 1'b0;
    sample();
    chk("t2_full", wr_ready, 0);
    chk("t2_level", level, 12);
    adv();

    // 5: push and pop together at full
    wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
    sample();
    chk("t5_wr_ready", wr_ready, 0);
    chk("t5_pop", rd_valid, 1);
    adv();
    wr_valid = 1'b0; rd_ready = 1'b0;
    sample();
    chk("t5_wr_ready_after", wr_ready, 1);
    adv();

    // 2 (cont.): drain back to back
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sample();
      chk("t2_no_bubble", rd_valid, 1);
      adv();
    end
    sample();
    chk("t2_empty", rd_valid, 0);
    chk("t2_sb", sb.size(), 0);
    adv();
    chk("t2_level0", level, 0);

    // 3: streaming 40 words, pointers wrap several times
    base = n_pop; acc = n_push;
    rd_ready = 1'b1;
    c = 0;
    while (c < 100 && n_pop < base + 40) begin
      wr_valid = (n_push - acc) < 40;
      wr_data = DW'(8'h40 + n_push - acc);
      sample();
      if (c >= 4 && c <= 40) chk("t3_level", level, 3);
      adv();
      c++;
    end
    wr_valid = 1'b0;
    chk("t3_count", n_pop - base, 40);

    // 4: alternating backpressure while pushing every cycle
    acc = n_push;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1;
      wr_data = DW'(8'h80 + n_push - acc);
      rd_ready = i[0];
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    c = 0;
    while (c < 40 && sb.size() > 0) begin
      step();
      c++;
    end
    sample();
    chk("t4_sb", sb.size(), 0);
    chk("t4_valid", rd_valid, 0);
    chk("t4_level", level, 0);
    adv();

    // 6: reset with a read in flight
    rd_ready = 1'b0;
    acc = n_push;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = DW'(8'hC0 + i);
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    sample();
    chk("t6_level_pre", level, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_ram_re", ram_re, 0);
    sb.delete();
    exp_wa = 0; exp_ra = 0; hold_prev = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    base = n_pop;
    wr_valid = 1'b1; wr_data = 8'hA1; rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t6_pops", n_pop - base, 1);
    chk("t6_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
